// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory access unit.
package mem_access_unit_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;
    localparam logic [3:0] WORD_BYTES = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP
    } state_e;

    // Encoding 2'b11 falls through to a full word.
    function automatic logic [2:0] size_of(input logic [1:0] mask_op);
        case (mask_op)
            MASK_B:  size_of = 3'd1;
            MASK_H:  size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: store byte enables/data across two words, load extract + extend.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rbeats_i,
    output logic [7:0]  be64_o,
    output logic [63:0] wd64_o,
    output logic [31:0] rdata_o
);

    logic [5:0]  sh;
    logic [31:0] r;

    always_comb begin
        sh     = {1'b0, off_i, 3'b000};
        be64_o = {4'b0000, size_mask(size_i)} << off_i;
        wd64_o = {32'b0, wdata_i} << sh;
        r      = rbeats_i[sh +: 32];
        case (size_i)
            3'd1:    rdata_o = {{24{sign_i & r[7]}}, r[7:0]};
            3'd2:    rdata_o = {{16{sign_i & r[15]}}, r[15:0]};
            default: rdata_o = r;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts one load/store, runs one or two word beats, pulses a response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit          ALLOW_SPLIT = 1'b1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              we_i,
    input  logic [1:0]        mask_op_i,
    input  logic              sign_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    state_e            state_q, state_d;
    logic              we_q, we_d, sign_q, sign_d, split_q, split_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d, beat0_q, beat0_d, rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d, err_q, err_d;
    logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    logic              idle, done;
    logic [3:0]        span;
    logic [1:0]        al_off;
    logic [2:0]        al_size;
    logic [31:0]       al_wdata, al_rdata;
    logic [63:0]       al_rbeats, wd64;
    logic [7:0]        be64;

    // In IDLE the aligner sees the incoming request so beat0 lanes register on acceptance.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        al_off    = idle ? addr_i[1:0] : off_q;
        al_size   = idle ? size_of(mask_op_i) : size_q;
        al_wdata  = idle ? wdata_i : wdata_q;
        al_rbeats = {bus_rdata_i, (state_q == ST_BEAT0) ? bus_rdata_i : beat0_q};
        span      = {2'b00, addr_i[1:0]} + {1'b0, size_of(mask_op_i)};
    end

    mem_lane_align u_align (
        .off_i    (al_off),
        .size_i   (al_size),
        .sign_i   (sign_q),
        .wdata_i  (al_wdata),
        .rbeats_i (al_rbeats),
        .be64_o   (be64),
        .wd64_o   (wd64),
        .rdata_o  (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        sign_d       = sign_q;
        split_d      = split_q;
        off_d        = off_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        beat0_d      = beat0_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = we_i;
                    sign_d  = sign_i;
                    off_d   = addr_i[1:0];
                    size_d  = size_of(mask_op_i);
                    wdata_d = wdata_i;
                    split_d = (span > WORD_BYTES);
                    if (split_d && !ALLOW_SPLIT) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        state_d     = ST_BEAT0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = we_i;
                        bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        bus_be_d    = be64[3:0];
                        bus_wdata_d = wd64[31:0];
                    end
                end
            end
            ST_BEAT0: begin
                if (bus_ack_i) begin
                    beat0_d = bus_rdata_i;
                    if (split_q) begin
                        state_d     = ST_BEAT1;
                        bus_addr_d  = bus_addr_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                        bus_be_d    = be64[7:4];
                        bus_wdata_d = wd64[63:32];
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_BEAT1: done = bus_ack_i;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (done) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            bus_req_d    = 1'b0;
            bus_we_d     = 1'b0;
            bus_addr_d   = '0;
            bus_be_d     = 4'b0000;
            bus_wdata_d  = 32'b0;
            if (!we_q) rdata_d = al_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            split_q      <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 3'd0;
            wdata_q      <= 32'b0;
            beat0_q      <= 32'b0;
            rdata_q      <= 32'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= 32'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            sign_q       <= sign_d;
            split_q      <= split_d;
            off_q        <= off_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            beat0_q      <= beat0_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_be_o     = bus_be_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random accesses against a byte-level model,
// split-disabled instance and reset/idle-ack corner sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        we = 1'b0, sg = 1'b0;
    logic [1:0]  mop = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0, bus_rdata = 32'h0;
    logic        ack = 1'b0, ack0 = 1'b0;

    logic        ready, resp, err, breq, bwe;
    logic [31:0] rdata, baddr, bwdata;
    logic [3:0]  bbe;
    logic        ready0, resp0, err0, breq0, bwe0;
    logic [31:0] rdata0, baddr0, bwdata0;
    logic [3:0]  bbe0;

    int total = 0;
    int bad = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALLOW_SPLIT(1'b1), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
        .we_i(we), .mask_op_i(mop), .sign_i(sg), .addr_i(addr), .wdata_i(wdata),
        .resp_valid_o(resp), .rdata_o(rdata), .err_o(err),
        .bus_req_o(breq), .bus_we_o(bwe), .bus_addr_o(baddr), .bus_be_o(bbe),
        .bus_wdata_o(bwdata), .bus_ack_i(ack), .bus_rdata_i(bus_rdata)
    );

    mem_access_unit #(.ALLOW_SPLIT(1'b0), .ADDR_W(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid0), .req_ready_o(ready0),
        .we_i(we), .mask_op_i(mop), .sign_i(sg), .addr_i(addr), .wdata_i(wdata),
        .resp_valid_o(resp0), .rdata_o(rdata0), .err_o(err0),
        .bus_req_o(breq0), .bus_we_o(bwe0), .bus_addr_o(baddr0), .bus_be_o(bbe0),
        .bus_wdata_o(bwdata0), .bus_ack_i(ack0), .bus_rdata_i(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Byte-level model: each request byte i lives in lane off+i of the {beat1,beat0} window.
    task automatic access(input logic w, input logic [1:0] m, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          output logic [3:0] obe0, output logic [3:0] obe1,
                          output logic [31:0] owd0, output logic [31:0] owd1);
        int size, off, nb, lat;
        logic [7:0]  ebe;
        logic [63:0] ewd, rb;
        logic [31:0] er, ebase;
        size = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
        off  = int'(a[1:0]);
        ebe  = 8'h0;
        ewd  = 64'h0;
        rb   = {rd1, rd0};
        er   = 32'h0;
        for (int i = 0; i < size; i++) begin
            ebe[off+i]           = 1'b1;
            ewd[(off+i)*8 +: 8]  = wd[i*8 +: 8];
            er[i*8 +: 8]         = rb[(off+i)*8 +: 8];
        end
        if (s && size < 4 && er[size*8-1])
            for (int i = size; i < 4; i++) er[i*8 +: 8] = 8'hFF;
        nb    = (off + size > 4) ? 2 : 1;
        ebase = a & 32'hFFFF_FFFC;
        obe0 = 4'h0; obe1 = 4'h0; owd0 = 32'h0; owd1 = 32'h0;

        @(negedge clk);
        chk("ready_before", {31'b0, ready}, 32'h1);
        we = w; mop = m; sg = s; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= waits; c++) begin
                @(negedge clk); lat++;
                chk("bus_req", {31'b0, breq}, 32'h1);
                chk("bus_we", {31'b0, bwe}, {31'b0, w});
                chk("bus_addr", baddr, ebase + 32'(4*b));
                chk("bus_be", {28'b0, bbe}, {28'b0, ebe[b*4 +: 4]});
                if (w) chk("bus_wdata", bwdata & bmask(bbe), ewd[b*32 +: 32]);
            end
            if (b == 0) begin obe0 = bbe; owd0 = w ? (bwdata & bmask(bbe)) : 32'h0; end
            else begin obe1 = bbe; owd1 = w ? (bwdata & bmask(bbe)) : 32'h0; end
            ack = 1'b1; bus_rdata = (b == 0) ? rd0 : rd1;
            @(posedge clk); #1 ack = 1'b0; bus_rdata = $urandom;
        end
        if (!w) last_rd = er;
        @(negedge clk); lat++;
        chk("resp_valid", {31'b0, resp}, 32'h1);
        chk("resp_err", {31'b0, err}, 32'h0);
        chk("latency", lat, nb + 1 + waits * nb);
        chk("bus_req_at_resp", {31'b0, breq}, 32'h0);
        chk("rdata", rdata, last_rd);
        @(negedge clk);
        chk("resp_pulse_end", {31'b0, resp}, 32'h0);
        chk("ready_after", {31'b0, ready}, 32'h1);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  m;
        logic        s;
        logic [31:0] a, wd;
        int          waits;
        logic [31:0] rd0, rd1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1, rd;
    } vec_t;

    vec_t tbl[10];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, ready}, 32'h1);
        chk({tag, "_resp"}, {31'b0, resp}, 32'h0);
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_breq"}, {31'b0, breq}, 32'h0);
        chk({tag, "_bwe"}, {31'b0, bwe}, 32'h0);
        chk({tag, "_baddr"}, baddr, 32'h0);
        chk({tag, "_bbe"}, {28'b0, bbe}, 32'h0);
        chk({tag, "_bwdata"}, bwdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1, a;
        tbl[0] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 0, 32'h80FFFFFF, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80};
        tbl[2] = '{1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1, 32'h80FFFFFF, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'h00000080};
        tbl[3] = '{1'b0, 2'b01, 1'b1, 32'h303, 32'h0, 1, 32'h12345678, 32'hABCDEFF0, 4'h8, 4'h1, 32'h0, 32'h0, 32'hFFFFF012};
        tbl[4] = '{1'b1, 2'b10, 1'b0, 32'h401, 32'hAABBCCDD, 0, 32'h0, 32'h0, 4'hE, 4'h1, 32'hBBCCDD00, 32'h000000AA, 32'h0};
        tbl[5] = '{1'b0, 2'b10, 1'b0, 32'h402, 32'h0, 0, 32'h11223344, 32'h55667788, 4'hC, 4'h3, 32'h0, 32'h0, 32'h77881122};
        tbl[6] = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h87654321, 32'h0, 4'hC, 4'h0, 32'h0, 32'h0, 32'hFFFF8765};
        tbl[7] = '{1'b0, 2'b11, 1'b1, 32'h008, 32'h0, 2, 32'hCAFEF00D, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 2'b00, 1'b1, 32'h001, 32'h0, 0, 32'h00007F00, 32'h0, 4'h2, 4'h0, 32'h0, 32'h0, 32'h0000007F};
        tbl[9] = '{1'b1, 2'b01, 1'b0, 32'h003, 32'h0000BEEF, 1, 32'h0, 32'h0, 4'h8, 4'h1, 32'hEF000000, 32'h000000BE, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].w, tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].waits,
                   tbl[i].rd0, tbl[i].rd1, be0, be1, wd0, wd1);
            chk($sformatf("vec%0d_be0", i), {28'b0, be0}, {28'b0, tbl[i].be0});
            chk($sformatf("vec%0d_be1", i), {28'b0, be1}, {28'b0, tbl[i].be1});
            if (tbl[i].w) begin
                chk($sformatf("vec%0d_wd0", i), wd0, tbl[i].wd0);
                chk($sformatf("vec%0d_wd1", i), wd1, tbl[i].wd1);
            end else begin
                chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rd);
            end
        end

        // Ack with no outstanding request must not start or finish anything.
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_resp", {31'b0, resp}, 32'h0);
        chk("idle_ack_breq", {31'b0, breq}, 32'h0);
        chk("idle_ack_ready", {31'b0, ready}, 32'h1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom & 32'h0000_0FFF;
            access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3),
                   mem_word(a & 32'hFFFF_FFFC), mem_word((a & 32'hFFFF_FFFC) + 32'h4),
                   be0, be1, wd0, wd1);
        end

        // Split-disabled instance: misaligned word errors out, aligned word goes to the bus.
        @(negedge clk);
        we = 1'b0; mop = 2'b10; sg = 1'b0; addr = 32'h502; req_valid0 = 1'b1;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("nosplit_resp", {31'b0, resp0}, 32'h1);
        chk("nosplit_err", {31'b0, err0}, 32'h1);
        chk("nosplit_breq", {31'b0, breq0}, 32'h0);
        chk("nosplit_ready_busy", {31'b0, ready0}, 32'h0);
        @(negedge clk);
        chk("nosplit_resp_end", {31'b0, resp0}, 32'h0);
        chk("nosplit_err_end", {31'b0, err0}, 32'h0);
        chk("nosplit_ready", {31'b0, ready0}, 32'h1);
        addr = 32'h500; req_valid0 = 1'b1;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("nosplit_al_breq", {31'b0, breq0}, 32'h1);
        chk("nosplit_al_addr", baddr0, 32'h500);
        chk("nosplit_al_be", {28'b0, bbe0}, 32'hF);
        ack0 = 1'b1; bus_rdata = 32'h13572468;
        @(posedge clk); #1 ack0 = 1'b0;
        @(negedge clk);
        chk("nosplit_al_resp", {31'b0, resp0}, 32'h1);
        chk("nosplit_al_err", {31'b0, err0}, 32'h0);
        chk("nosplit_al_rdata", rdata0, 32'h13572468);

        // Reset during the second beat of a split load abandons it silently.
        @(negedge clk);
        we = 1'b0; mop = 2'b01; sg = 1'b1; addr = 32'h303; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        ack = 1'b1; bus_rdata = 32'h12000000;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        chk("midrst_beat1_addr", baddr, 32'h304);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", {31'b0, resp}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
